datapath_pipe: RTL and testbench

Parametrised two-stage register-file datapath, the next generation of the team's 8×16-bit control-word datapath. It accepts one control word per cycle over a valid/ready handshake and reads operands in stage 1. Stage 2 executes and writes back, with forwarding and flag-register update. An external data-in stall supports load-type words. It sits under the microsequencer as the execution core; the full register file is exported for debug and testbench comparison.

---
 rtl/datapath_pipe.sv | 183 ++++++++++++++++++
 tb/tb_datapath_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe.sv
// rtl/datapath_pipe.sv - two-stage register-file datapath with forwarding, flags and load stall
module datapath_pipe #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS),
  localparam int CW_W = 3*AW + 8 + WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CW_W-1:0]        cw,
  input  logic                   cw_valid,
  output logic                   cw_ready,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   data_in_valid,
  output logic [WIDTH-1:0]       a_bus,
  output logic [WIDTH-1:0]       b_bus,
  output logic [WIDTH-1:0]       f_out,
  output logic                   wb_valid,
  output logic                   v,
  output logic                   c,
  output logic                   n,
  output logic                   z,
  output logic [NREGS*WIDTH-1:0] reg_flat
);

  // control word field positions, LSB upward
  localparam int FL_BIT = WIDTH;
  localparam int RW_BIT = WIDTH + 1;
  localparam int MD_BIT = WIDTH + 2;
  localparam int FS_LSB = WIDTH + 3;
  localparam int MB_BIT = WIDTH + 7;
  localparam int BA_LSB = WIDTH + 8;
  localparam int AA_LSB = BA_LSB + AW;
  localparam int DA_LSB = AA_LSB + AW;

  logic [WIDTH-1:0] cw_const;
  logic [AW-1:0]    cw_da, cw_aa, cw_ba;
  logic [3:0]       cw_fs;
  logic             cw_mb, cw_md, cw_rw, cw_fl;

  assign cw_const = cw[WIDTH-1:0];
  assign cw_fl    = cw[FL_BIT];
  assign cw_rw    = cw[RW_BIT];
  assign cw_md    = cw[MD_BIT];
  assign cw_fs    = cw[FS_LSB +: 4];
  assign cw_mb    = cw[MB_BIT];
  assign cw_ba    = cw[BA_LSB +: AW];
  assign cw_aa    = cw[AA_LSB +: AW];
  assign cw_da    = cw[DA_LSB +: AW];

  // architectural state
  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [3:0]                  flags_q, flags_d;   // {v,c,n,z}

  // stage-2 registers
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0]    da_q, da_d;
  logic [3:0]       fs_q, fs_d;
  logic             md_q, md_d, rw_q, rw_d, fl_q, fl_d;

  logic             stall, retire, accept;
  logic [WIDTH-1:0] wb_val;

  // ALU signals
  logic [WIDTH-1:0] alu_bt;
  logic             alu_cin;
  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c, alu_v;

  // a load word without its data freezes both stages
  assign stall    = s2_valid_q & md_q & ~data_in_valid;
  assign retire   = s2_valid_q & ~stall;
  assign accept   = cw_valid & ~stall;
  assign cw_ready = ~stall;
  assign wb_valid = retire;
  assign wb_val   = md_q ? data_in : alu_f;
  assign f_out    = wb_val;
  assign a_bus    = a_q;
  assign b_bus    = b_q;
  assign {v, c, n, z} = flags_q;
  assign reg_flat = regs_q;

  // stage-2 execute: adder-family codes share one WIDTH+1 adder, the rest are logic/shift
  always_comb begin
    alu_bt  = '0;
    alu_cin = 1'b0;
    alu_f   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (fs_q)
      4'd1:    alu_cin = 1'b1;
      4'd2:    alu_bt  = b_q;
      4'd3:    begin alu_bt = b_q;  alu_cin = 1'b1; end
      4'd4:    alu_bt  = ~b_q;
      4'd5:    begin alu_bt = ~b_q; alu_cin = 1'b1; end
      4'd6:    alu_bt  = '1;
      default: ;
    endcase
    alu_sum = {1'b0, a_q} + {1'b0, alu_bt} + {{WIDTH{1'b0}}, alu_cin};
    if (!fs_q[3]) begin
      alu_f = alu_sum[WIDTH-1:0];
      alu_c = alu_sum[WIDTH];
      if ((fs_q >= 4'd1) && (fs_q <= 4'd6))
        alu_v = (a_q[WIDTH-1] == alu_bt[WIDTH-1]) && (alu_f[WIDTH-1] != a_q[WIDTH-1]);
    end else begin
      case (fs_q)
        4'd8:    alu_f = a_q & b_q;
        4'd9:    alu_f = a_q | b_q;
        4'd10:   alu_f = a_q ^ b_q;
        4'd11:   alu_f = ~a_q;
        4'd12:   alu_f = b_q;
        4'd13:   begin alu_f = {1'b0, b_q[WIDTH-1:1]}; alu_c = b_q[0]; end
        4'd14:   begin alu_f = {b_q[WIDTH-2:0], 1'b0}; alu_c = b_q[WIDTH-1]; end
        default: alu_f = '0;
      endcase
    end
  end

  // writeback, flag load, stage-1 operand read with forwarding, stage-2 advance
  always_comb begin
    regs_d     = regs_q;
    flags_d    = flags_q;
    s2_valid_d = s2_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    da_d       = da_q;
    fs_d       = fs_q;
    md_d       = md_q;
    rw_d       = rw_q;
    fl_d       = fl_q;

    if (retire && rw_q)
      regs_d[da_q] = wb_val;
    if (retire && fl_q && !md_q)
      flags_d = {alu_v, alu_c, alu_f[WIDTH-1], (alu_f == '0)};

    if (!stall) begin
      s2_valid_d = accept;
      if (accept) begin
        a_d = (retire && rw_q && (da_q == cw_aa)) ? wb_val : regs_q[cw_aa];
        if (cw_mb)
          b_d = cw_const;
        else
          b_d = (retire && rw_q && (da_q == cw_ba)) ? wb_val : regs_q[cw_ba];
        da_d = cw_da;
        fs_d = cw_fs;
        md_d = cw_md;
        rw_d = cw_rw;
        fl_d = cw_fl;
      end
    end
  end

  // state registers; reset drops any in-flight word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '0;
      flags_q    <= '0;
      s2_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      da_q       <= '0;
      fs_q       <= '0;
      md_q       <= 1'b0;
      rw_q       <= 1'b0;
      fl_q       <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      flags_q    <= flags_d;
      s2_valid_q <= s2_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      da_q       <= da_d;
      fs_q       <= fs_d;
      md_q       <= md_d;
      rw_q       <= rw_d;
      fl_q       <= fl_d;
    end
  end

endmodule

// File: tb/tb_datapath_pipe.sv
// tb/tb_datapath_pipe.sv - scoreboard bench for datapath_pipe (16x8 random/directed, 8x4 directed)
module tb_datapath_pipe;

  localparam int W   = 16;
  localparam int N   = 8;
  localparam int A   = 3;
  localparam int CW  = 3*A + 8 + W;
  localparam int W2  = 8;
  localparam int N2  = 4;
  localparam int A2  = 2;
  localparam int CW2 = 3*A2 + 8 + W2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          rst_n;
  logic [CW-1:0] cw;
  logic          cw_valid, cw_ready;
  logic [W-1:0]  data_in;
  logic          data_in_valid;
  logic [W-1:0]  a_bus, b_bus, f_out;
  logic          wb_valid, v, c, n, z;
  logic [N*W-1:0] reg_flat;

  // small instance
  logic           rst_n2;
  logic [CW2-1:0] cw2;
  logic           cw2_valid, cw_ready2;
  logic [W2-1:0]  data_in2;
  logic           data_in_valid2;
  logic [W2-1:0]  a_bus2, b_bus2, f_out2;
  logic           wb_valid2, v2, c2, n2, z2;
  logic [N2*W2-1:0] reg_flat2;

  datapath_pipe #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .rst_n(rst_n), .cw(cw), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .data_in(data_in), .data_in_valid(data_in_valid), .a_bus(a_bus), .b_bus(b_bus),
    .f_out(f_out), .wb_valid(wb_valid), .v(v), .c(c), .n(n), .z(z), .reg_flat(reg_flat)
  );

  datapath_pipe #(.WIDTH(W2), .NREGS(N2)) dut_small (
    .clk(clk), .rst_n(rst_n2), .cw(cw2), .cw_valid(cw2_valid), .cw_ready(cw_ready2),
    .data_in(data_in2), .data_in_valid(data_in_valid2), .a_bus(a_bus2), .b_bus(b_bus2),
    .f_out(f_out2), .wb_valid(wb_valid2), .v(v2), .c(c2), .n(n2), .z(z2), .reg_flat(reg_flat2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]   a, b, f;
    logic [N*W-1:0] regs;
    logic [3:0]     flags;
  } exp_t;
  exp_t sbq[$];

  // architectural reference: words execute one at a time, in order
  int unsigned mr[N];
  logic [3:0]  mflags;

  function automatic logic [CW-1:0] mk(input logic [2:0] da, input logic [2:0] aa, input logic [2:0] ba,
                                       input logic mb, input logic [3:0] fs, input logic md,
                                       input logic rw, input logic fl, input logic [15:0] k);
    return {da, aa, ba, mb, fs, md, rw, fl, k};
  endfunction

  function automatic logic [CW2-1:0] mk2(input logic [1:0] da, input logic [1:0] aa, input logic [1:0] ba,
                                         input logic mb, input logic [3:0] fs, input logic md,
                                         input logic rw, input logic fl, input logic [7:0] k);
    return {da, aa, ba, mb, fs, md, rw, fl, k};
  endfunction

  task automatic model_exec(input logic [CW-1:0] w, input logic [15:0] ld);
    longint M = 65535;
    longint av, bv, bt, cin, s, sa, sb, ss, fv, cv, vv, wbv;
    int fs;
    logic [2:0] da, aa, ba;
    logic mb, md, rw, fl;
    exp_t e;
    fl = w[16]; rw = w[17]; md = w[18]; fs = int'(w[22:19]); mb = w[23];
    ba = w[26:24]; aa = w[29:27]; da = w[32:30];
    av = longint'(mr[aa]);
    bv = mb ? longint'(w[15:0]) : longint'(mr[ba]);
    bt = 0; cin = 0; cv = 0; vv = 0;
    case (fs)
      1: cin = 1;
      2: bt = bv;
      3: begin bt = bv; cin = 1; end
      4: bt = (~bv) & M;
      5: begin bt = (~bv) & M; cin = 1; end
      6: bt = M;
      default: ;
    endcase
    if (fs < 8) begin
      s  = av + bt + cin;
      fv = s & M;
      cv = (s >> 16) & 1;
      sa = (av >= 32768) ? av - 65536 : av;
      sb = (bt >= 32768) ? bt - 65536 : bt;
      ss = sa + sb + cin;
      vv = (fs >= 1 && fs <= 6 && (ss > 32767 || ss < -32768)) ? 1 : 0;
    end else begin
      case (fs)
        8:  fv = av & bv;
        9:  fv = av | bv;
        10: fv = av ^ bv;
        11: fv = (~av) & M;
        12: fv = bv;
        13: begin fv = bv >> 1; cv = bv & 1; end
        14: begin fv = (bv << 1) & M; cv = (bv >> 15) & 1; end
        default: fv = 0;
      endcase
    end
    wbv = md ? longint'(ld) : fv;
    e.a = av[15:0];
    e.b = bv[15:0];
    e.f = wbv[15:0];
    if (rw) mr[da] = int'(unsigned'(wbv[31:0]));
    if (fl && !md) mflags = {vv[0], cv[0], fv[15], (fv == 0)};
    for (int i = 0; i < N; i++) e.regs[i*W +: W] = mr[i][15:0];
    e.flags = mflags;
    sbq.push_back(e);
  endtask

  // driver bookkeeping: load data belonging to the word now in stage 2
  logic [15:0] s2_ld = 16'h0;
  bit rnd_div = 1'b0;

  task automatic step(input bit vld, input logic [CW-1:0] w, input logic [15:0] ld, input bit dv, output bit acc);
    @(negedge clk);
    cw_valid = vld;
    cw = w;
    data_in = s2_ld;
    data_in_valid = dv;
    #1;
    acc = vld && cw_ready;
    if (acc) begin
      model_exec(w, ld);
      s2_ld = ld;
    end
  endtask

  task automatic send(input logic [CW-1:0] w, input logic [15:0] ld);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      step(1'b1, w, ld, rnd_div ? ($urandom % 3 != 0) : 1'b1, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", {127'd0, acc}, 128'd1);
  endtask

  task automatic idle(input int k);
    bit acc;
    repeat (k) step(1'b0, '0, 16'h0, 1'b1, acc);
  endtask

  function automatic logic [15:0] rg(input int i);
    return reg_flat[i*W +: W];
  endfunction

  // monitor: every retiring word is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && wb_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 128'(sbq.size()), 128'd1);
        end else begin
          e = sbq.pop_front();
          chk("sb_a_bus", a_bus, e.a);
          chk("sb_b_bus", b_bus, e.b);
          chk("sb_f_out", f_out, e.f);
          @(posedge clk);
          #1;
          chk("sb_regs", reg_flat, e.regs);
          chk("sb_flags", {v, c, n, z}, e.flags);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [CW-1:0] w2;
    for (int i = 0; i < N; i++) mr[i] = 0;
    mflags = 4'b0;
    rst_n = 1'b0; rst_n2 = 1'b0;
    cw = '0; cw_valid = 1'b0; data_in = '0; data_in_valid = 1'b1;
    cw2 = '0; cw2_valid = 1'b0; data_in2 = '0; data_in_valid2 = 1'b1;
    #2;
    chk("rst_regs", reg_flat, 128'd0);
    chk("rst_flags", {v, c, n, z}, 4'b0000);
    chk("rst_ready", cw_ready, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_ab", {a_bus, b_bus}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rst_n2 = 1'b1;
    idle(2);
    chk("idle_regs", reg_flat, 128'd0);
    chk("idle_ready", cw_ready, 1'b1);

    // constants then dependent add, back-to-back
    send(mk(3'd1, 3'd0, 3'd0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 16'h7FFF), 16'h0);
    send(mk(3'd2, 3'd0, 3'd0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 16'h0001), 16'h0);
    send(mk(3'd3, 3'd1, 3'd2, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 16'h0), 16'h0);
    idle(2);
    chk("add_r3", rg(3), 16'h8000);
    chk("add_flags", {v, c, n, z}, 4'b1010);

    // subtract to zero, then a flag-neutral AND
    send(mk(3'd4, 3'd2, 3'd2, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 16'h0), 16'h0);
    idle(2);
    chk("sub_r4", rg(4), 16'h0000);
    chk("sub_flags", {v, c, n, z}, 4'b0101);
    send(mk(3'd5, 3'd1, 3'd2, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 16'h0), 16'h0);
    idle(2);
    chk("and_r5", rg(5), 16'h0001);
    chk("and_flags_kept", {v, c, n, z}, 4'b0101);

    // shifts
    send(mk(3'd6, 3'd0, 3'd0, 1'b1, 4'd14, 1'b0, 1'b1, 1'b1, 16'h8001), 16'h0);
    idle(2);
    chk("shl_r6", rg(6), 16'h0002);
    chk("shl_flags", {v, c, n, z}, 4'b0100);
    send(mk(3'd7, 3'd0, 3'd0, 1'b1, 4'd13, 1'b0, 1'b1, 1'b1, 16'h8001), 16'h0);
    idle(2);
    chk("shr_r7", rg(7), 16'h4000);
    chk("shr_flags", {v, c, n, z}, 4'b0100);

    // load stall: data_in withheld 3 cycles, next word must wait
    send(mk(3'd5, 3'd0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 16'h0), 16'hBEEF);
    w2 = mk(3'd0, 3'd5, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, w2, 16'h0, 1'b0, acc);
      chk("stall_ready", cw_ready, 1'b0);
      chk("stall_wb_valid", wb_valid, 1'b0);
    end
    step(1'b1, w2, 16'h0, 1'b1, acc);
    chk("stall_release_acc", {127'd0, acc}, 128'd1);
    idle(2);
    chk("load_r5", rg(5), 16'hBEEF);
    chk("load_fwd_r0", rg(0), 16'hBEEF);
    chk("load_flags_kept", {v, c, n, z}, 4'b0100);

    // randomized traffic against the reference
    rnd_div = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) idle(1);
      else send(mk(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   1'($urandom % 2), 4'($urandom_range(0, 15)), 1'($urandom % 6 == 0),
                   1'($urandom % 5 != 0), 1'($urandom % 2), 16'($urandom)),
                16'($urandom));
    end
    rnd_div = 1'b0;
    idle(3);
    chk("sb_drained", 128'(sbq.size()), 128'd0);

    // 8-bit, 4-register instance
    @(negedge clk);
    cw2 = mk2(2'd2, 2'd0, 2'd0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 8'h33); cw2_valid = 1'b1;
    @(negedge clk);
    cw2 = mk2(2'd1, 2'd0, 2'd0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 8'hFF);
    @(negedge clk);
    cw2 = mk2(2'd2, 2'd1, 2'd0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 8'h00);
    @(negedge clk);
    cw2_valid = 1'b0;
    #1;
    chk("w8_inc_wb_valid", wb_valid2, 1'b1);
    chk("w8_inc_f", f_out2, 8'h00);
    @(negedge clk);
    chk("w8_r1", reg_flat2[15:8], 8'hFF);
    chk("w8_r2", reg_flat2[23:16], 8'h00);
    chk("w8_flags", {v2, c2, n2, z2}, 4'b0101);
    cw2 = mk2(2'd3, 2'd0, 2'd0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 8'h5A); cw2_valid = 1'b1;
    @(negedge clk);
    cw2_valid = 1'b0;
    #1;
    chk("w8_inflight", {wb_valid2, f_out2}, {1'b1, 8'h5A});
    rst_n2 = 1'b0;
    #1;
    chk("w8_rst_regs", reg_flat2, 32'd0);
    chk("w8_rst_wb_valid", wb_valid2, 1'b0);
    chk("w8_rst_ready", cw_ready2, 1'b1);
    @(negedge clk);
    rst_n2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("w8_r3_discarded", reg_flat2[31:24], 8'h00);
    chk("w8_rst_flags", {v2, c2, n2, z2}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
